redmule_clk_ctrl: RTL and testbench

// - Clock-enable and wake controller directly upstream of the RedMulE clock gate and X-interface issue path.
// - Drives the tc_clk_gating enable.
// - Wakes the gated RedMulE domain on a core offload request or while the accelerator is busy.
// - Holds the issue handshake until the clock is running, then re-gates after a programmable idle window.

---
 rtl/redmule_clk_ctrl.sv | 168 ++++++++++++++++
 tb/tb_redmule_clk_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_clk_ctrl.sv
// redmule_clk_ctrl: clock-enable and wake controller placed in front of the
// RedMulE clock gate and the X-interface issue path. It wakes the gated
// domain on an offload request or while the accelerator is busy. It keeps the
// issue handshake closed until the clock runs, and re-gates after an idle
// window.
// Optional feature: define REDMULE_CLK_CTRL_STATS_EN to add the gated_cycles_o
// statistics counter, which counts cycles spent gated while enabled.

// Elaboration-time parameter range check, kept out of the functional logic.
module redmule_clk_ctrl_param_chk #(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned CntWidth   = 16
);
    localparam longint unsigned CntLimit = 64'd1 << CntWidth;

    if (64'(IdleCycles) >= CntLimit) begin : g_idle_range
        $error("redmule_clk_ctrl: IdleCycles does not fit in CntWidth bits");
    end
    if (64'(WakeCycles) >= CntLimit) begin : g_wake_range
        $error("redmule_clk_ctrl: WakeCycles does not fit in CntWidth bits");
    end
endmodule

module redmule_clk_ctrl #(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                test_mode_i,
    input  logic                fetch_enable_i,
    input  logic                busy_i,
    input  logic                xif_issue_valid_i,
    output logic                xif_issue_ready_o,
    output logic                xif_issue_valid_o,
    input  logic                xif_issue_ready_i,
    output logic                clk_en_o,
`ifdef REDMULE_CLK_CTRL_STATS_EN
    output logic [CntWidth-1:0] gated_cycles_o,
`endif
    output logic                idle_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [CntWidth-1:0] CntZero  = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne   = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] IdleLoad = (IdleCycles == 0) ? CntZero : CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] WakeLoad = (WakeCycles == 0) ? CntZero : CntWidth'(WakeCycles - 1);

    redmule_clk_ctrl_param_chk #(
        .IdleCycles (IdleCycles),
        .WakeCycles (WakeCycles),
        .CntWidth   (CntWidth)
    ) u_param_chk ();

    state_e              state_r;
    logic [CntWidth-1:0] wake_cnt_r;
    logic [CntWidth-1:0] idle_cnt_r;
    logic                clk_en_r;
    logic                idle_r;
    logic                open_s;
    logic                activity_s;

    // New work for the accelerator: an offload request or a running operation.
    assign activity_s = busy_i | xif_issue_valid_i;

    // Issue path is open only while the clock runs; DFT forces it open.
    assign open_s            = (state_r == ST_RUN) | (state_r == ST_DRAIN) | test_mode_i;
    assign xif_issue_valid_o = xif_issue_valid_i & open_s;
    assign xif_issue_ready_o = xif_issue_ready_i & open_s;
    assign clk_en_o          = clk_en_r | test_mode_i;
    assign idle_o            = idle_r;

    // Power FSM with registered clock enable and idle flag; enable follows the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_OFF;
            wake_cnt_r <= CntZero;
            idle_cnt_r <= CntZero;
            clk_en_r   <= 1'b0;
            idle_r     <= 1'b1;
        end else begin
            clk_en_r <= 1'b1;
            idle_r   <= 1'b0;
            case (state_r)
                ST_OFF: begin
                    if (fetch_enable_i && activity_s) begin
                        if (WakeCycles == 0) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r    <= ST_WAKE;
                            wake_cnt_r <= WakeLoad;
                        end
                    end else begin
                        clk_en_r <= 1'b0;
                        idle_r   <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // A wake always completes, even if fetch_enable_i drops meanwhile.
                    if (wake_cnt_r == CntZero) begin
                        state_r <= ST_RUN;
                    end else begin
                        wake_cnt_r <= wake_cnt_r - CntOne;
                    end
                end
                ST_RUN: begin
                    if (!activity_s) begin
                        // Disabled domain skips the idle window once the work is done.
                        if (!fetch_enable_i || (IdleCycles == 0)) begin
                            state_r  <= ST_OFF;
                            clk_en_r <= 1'b0;
                            idle_r   <= 1'b1;
                        end else begin
                            state_r    <= ST_DRAIN;
                            idle_cnt_r <= IdleLoad;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Fresh activity wins over an expiring idle window.
                    if (activity_s) begin
                        state_r <= ST_RUN;
                    end else if ((idle_cnt_r == CntZero) || !fetch_enable_i) begin
                        state_r  <= ST_OFF;
                        clk_en_r <= 1'b0;
                        idle_r   <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r - CntOne;
                    end
                end
                default: begin
                    state_r  <= ST_OFF;
                    clk_en_r <= 1'b0;
                    idle_r   <= 1'b1;
                end
            endcase
        end
    end

`ifdef REDMULE_CLK_CTRL_STATS_EN
    logic [CntWidth-1:0] gated_cnt_r;

    // Saturating count of cycles spent gated while the domain is enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gated_cnt_r <= CntZero;
        end else if ((state_r == ST_OFF) && fetch_enable_i && (gated_cnt_r != {CntWidth{1'b1}})) begin
            gated_cnt_r <= gated_cnt_r + CntOne;
        end else begin
            gated_cnt_r <= gated_cnt_r;
        end
    end

    assign gated_cycles_o = gated_cnt_r;
`endif

endmodule

// File: tb/tb_redmule_clk_ctrl.sv
// Self-checking bench for redmule_clk_ctrl (IdleCycles=16, WakeCycles=2).
// Define REDMULE_CLK_CTRL_STATS_EN to also check the gated-cycle counter.
`timescale 1ns/1ps

module tb_redmule_clk_ctrl;

    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          test_mode_i;
    logic          fetch_enable_i;
    logic          busy_i;
    logic          xif_issue_valid_i;
    logic          xif_issue_ready_o;
    logic          xif_issue_valid_o;
    logic          xif_issue_ready_i;
    logic          clk_en_o;
    logic          idle_o;
`ifdef REDMULE_CLK_CTRL_STATS_EN
    logic [CW-1:0] gated_cycles_o;
`endif

    redmule_clk_ctrl #(
        .IdleCycles (16),
        .WakeCycles (2),
        .CntWidth   (CW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .test_mode_i       (test_mode_i),
        .fetch_enable_i    (fetch_enable_i),
        .busy_i            (busy_i),
        .xif_issue_valid_i (xif_issue_valid_i),
        .xif_issue_ready_o (xif_issue_ready_o),
        .xif_issue_valid_o (xif_issue_valid_o),
        .xif_issue_ready_i (xif_issue_ready_i),
        .clk_en_o          (clk_en_o),
`ifdef REDMULE_CLK_CTRL_STATS_EN
        .gated_cycles_o    (gated_cycles_o),
`endif
        .idle_o            (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    // Count completed issue handshakes on the RedMulE side.
    always @(posedge clk_i) begin
        if (!rst_i && xif_issue_valid_o && xif_issue_ready_o) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic       fe;
        logic       busy;
        logic       valid;
        logic       rdy;
        logic       tm;
        logic [3:0] exp;   // {clk_en, idle, valid_o, ready_o}
    } vec_t;

    vec_t       vecs[13];
    logic [3:0] exp_q[$];
    int         idx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {clk_en_o, idle_o, xif_issue_valid_o, xif_issue_ready_o};
    endfunction

    initial begin
        int n;
        int hs0;
        int drops;
        logic [3:0] e;

        // Each row: inputs held across one edge, outputs expected just after it.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100}; // disabled, valid pending: stay gated
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1000}; // OFF->WAKE, enable rises
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1000}; // WAKE, issue still held
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1011}; // RUN, path open
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001}; // busy keeps RUN
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001}; // RUN->DRAIN
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001}; // DRAIN->RUN on busy
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001}; // RUN->DRAIN again
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100}; // disable cuts DRAIN short
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100}; // no wake when disabled
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111}; // test mode forces enable/path
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};

        // Reset state.
        rst_i = 1'b1; test_mode_i = 1'b0; fetch_enable_i = 1'b1; busy_i = 1'b0;
        xif_issue_valid_i = 1'b0; xif_issue_ready_i = 1'b1;
        #12;
        check("reset_outs", 32'(outs()), 32'b0100);
`ifdef REDMULE_CLK_CTRL_STATS_EN
        check("reset_gated", 32'(gated_cycles_o), 32'd0);
`endif
        rst_i = 1'b0;

        // Enabled, no traffic for 50 cycles: stays gated.
        repeat (50) tick();
        check("idle50_outs", 32'(outs()), 32'b0100);
`ifdef REDMULE_CLK_CTRL_STATS_EN
        check("idle50_gated", 32'(gated_cycles_o), 32'd50);
`endif

        // Table-driven vectors through a scoreboard queue.
        for (int i = 0; i < 13; i++) begin
            fetch_enable_i = vecs[i].fe; busy_i = vecs[i].busy;
            xif_issue_valid_i = vecs[i].valid; xif_issue_ready_i = vecs[i].rdy;
            test_mode_i = vecs[i].tm;
            exp_q.push_back(vecs[i].exp);
            idx_q.push_back(i);
            tick();
            e = exp_q.pop_front();
            n = idx_q.pop_front();
            check($sformatf("vec%0d", n), 32'(outs()), 32'(e));
        end
        test_mode_i = 1'b0; xif_issue_valid_i = 1'b0;
        tick();

        // Wake latency: valid from t0, enable at t0+1, ready at t0+3, one handshake.
        hs0 = hs_cnt;
        fetch_enable_i = 1'b1; xif_issue_valid_i = 1'b1; xif_issue_ready_i = 1'b1;
        check("wake_t0_ready", 32'(xif_issue_ready_o), 32'd0);
        tick();
        check("wake_t1", 32'({clk_en_o, xif_issue_ready_o}), 32'b10);
        tick();
        check("wake_t2", 32'({clk_en_o, xif_issue_ready_o}), 32'b10);
        tick();
        check("wake_t3", 32'({clk_en_o, xif_issue_ready_o, xif_issue_valid_o}), 32'b111);
        tick();
        xif_issue_valid_i = 1'b0;
        repeat (3) tick();
        check("wake_hs_once", 32'(hs_cnt - hs0), 32'd1);

        // Busy for 100 cycles, then idle window of 16: enable falls 17 cycles later.
        busy_i = 1'b1;
        repeat (100) tick();
        check("busy_hold_en", 32'(clk_en_o), 32'd1);
        busy_i = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (clk_en_o && n < 40);
        check("drain_len", 32'(n), 32'd17);

        // Valid arrives as the idle counter reaches 0: back to RUN, handshake done.
        busy_i = 1'b1;
        repeat (5) tick();
        busy_i = 1'b0;
        repeat (16) tick();
        check("drain_edge_pre", 32'(clk_en_o), 32'd1);
        hs0 = hs_cnt;
        xif_issue_valid_i = 1'b1; xif_issue_ready_i = 1'b1;
        check("drain_edge_open", 32'(xif_issue_ready_o), 32'd1);
        tick();
        check("drain_edge_run", 32'(clk_en_o), 32'd1);
        xif_issue_valid_i = 1'b0;
        tick();
        check("drain_edge_after", 32'(clk_en_o), 32'd1);
        check("drain_edge_hs", 32'(hs_cnt - hs0), 32'd1);

        // fetch_enable dropped while busy: hold enable, then gate immediately.
        busy_i = 1'b1;
        tick();
        fetch_enable_i = 1'b0;
        drops = 0;
        repeat (10) begin
            tick();
            if (!clk_en_o) drops++;
        end
        check("fe_drop_busy_drops", 32'(drops), 32'd0);
        busy_i = 1'b0;
        tick();
        check("fe_drop_gate", 32'({clk_en_o, idle_o}), 32'b01);

        // Test mode in OFF: pass-through in the same cycle.
        xif_issue_valid_i = 1'b1; xif_issue_ready_i = 1'b1;
        test_mode_i = 1'b1;
        #1;
        check("tm_same_cycle", 32'(outs()), 32'b1111);
        test_mode_i = 1'b0;
        #1;
        check("tm_release", 32'(outs()), 32'b0100);
        xif_issue_valid_i = 1'b0;

        // Asynchronous reset in RUN: enable drops at once.
        fetch_enable_i = 1'b1; busy_i = 1'b1;
        repeat (4) tick();
        check("rst_pre_run", 32'({clk_en_o, xif_issue_ready_o}), 32'b11);
        #3;
        rst_i = 1'b1;
        #1;
        check("async_rst", 32'(outs()), 32'b0100);
`ifdef REDMULE_CLK_CTRL_STATS_EN
        check("async_rst_gated", 32'(gated_cycles_o), 32'd0);
`endif
        busy_i = 1'b0;
        #10;
        rst_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
